// File: rtl/spi_fifo_sequencer_pkg.sv
// Shared types and constants for the SPI FIFO sequencer.
package spi_seq_pkg;
    localparam int WORD_W       = 24;
    localparam int EOF_BIT      = 24;
    localparam int HALF_PERIODS = 48;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STALL, GAP} state_t;
endpackage

// File: rtl/spi_fifo_sequencer_sclk_gen.sv
// SCLK divider: flags the rising/falling half-period wraps of one word and the final fall.
module spi_sclk_gen #(
    parameter int CLK_DIV      = 4,
    parameter int HALF_PERIODS = 48
) (
    input  logic clock,
    input  logic sclr,
    input  logic run,
    output logic rise_stb,
    output logic fall_stb,
    output logic done_stb
);
    localparam int HPW = $clog2(HALF_PERIODS);

    logic [7:0]     div_cnt;
    logic [HPW-1:0] hp_cnt;
    logic           wrap;

    // Even half-periods end in a rising SCLK edge, odd ones in a falling edge.
    assign wrap     = run && (div_cnt == 8'(CLK_DIV - 1));
    assign rise_stb = wrap && !hp_cnt[0];
    assign fall_stb = wrap && hp_cnt[0];
    assign done_stb = fall_stb && (hp_cnt == HPW'(HALF_PERIODS - 1));

    always_ff @(posedge clock) begin
        if (sclr || !run) begin
            div_cnt <= '0;
            hp_cnt  <= '0;
        end else if (wrap) begin
            div_cnt <= '0;
            hp_cnt  <= done_stb ? '0 : hp_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_fifo_sequencer.sv
// Pops command words from the TX FIFO, shifts them out SPI mode 0 and frames CS on the eof flag.
module spi_fifo_sequencer
    import spi_seq_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2,
    parameter int WORD_W  = spi_seq_pkg::WORD_W
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [WORD_W:0]   fifo_q,
    output logic              fifo_rdreq,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);
    state_t            state;
    logic [WORD_W-2:0] tx_sr;   // bits still to send after the one on spi_mosi
    logic [WORD_W-1:0] rx_sr;
    logic              eof;
    logic [7:0]        gap_cnt;
    logic              rise_stb, fall_stb, done_stb;

    spi_sclk_gen #(
        .CLK_DIV      (CLK_DIV),
        .HALF_PERIODS (2 * WORD_W)
    ) u_sclk (
        .clock    (clock),
        .sclr     (sclr),
        .run      (state == SHIFT),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .done_stb (done_stb)
    );

    always_ff @(posedge clock) begin
        if (sclr) begin
            state      <= IDLE;
            spi_sclk   <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_mosi   <= 1'b0;
            fifo_rdreq <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            eof        <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            fifo_rdreq <= 1'b0;
            rx_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    // CS drops together with the pop so the frame includes the LOAD cycle.
                    if (enable && !fifo_empty) begin
                        state      <= LOAD;
                        fifo_rdreq <= 1'b1;
                        spi_cs_n   <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    tx_sr    <= fifo_q[WORD_W-2:0];
                    eof      <= fifo_q[WORD_W];
                    spi_mosi <= fifo_q[WORD_W-1];
                    spi_cs_n <= 1'b0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (rise_stb) begin
                        spi_sclk <= 1'b1;
                        rx_sr    <= {rx_sr[WORD_W-2:0], spi_miso};
                    end
                    if (fall_stb) begin
                        spi_sclk <= 1'b0;
                        if (!done_stb) begin
                            spi_mosi <= tx_sr[WORD_W-2];
                            tx_sr    <= {tx_sr[WORD_W-3:0], 1'b0};
                        end
                    end
                    if (done_stb) begin
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                        if (eof) begin
                            state    <= GAP;
                            spi_cs_n <= 1'b1;
                            gap_cnt  <= '0;
                        end else if (!fifo_empty) begin
                            state      <= LOAD;
                            fifo_rdreq <= 1'b1;
                        end else begin
                            state <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (!fifo_empty) begin
                        state      <= LOAD;
                        fifo_rdreq <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'(CS_GAP - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_fifo_sequencer.sv
// Bench for spi_fifo_sequencer: FIFO and SPI-slave models around a CLK_DIV=4 and a CLK_DIV=1 instance.
module tb_spi_fifo_sequencer;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        sclr;
    logic        en_a, empty_a, rdreq_a, sclk_a, cs_a, mosi_a, miso_a, rxv_a, busy_a;
    logic [24:0] q_a;
    logic [23:0] rxd_a;
    logic        en_b, empty_b, rdreq_b, sclk_b, cs_b, mosi_b, miso_b, rxv_b, busy_b;
    logic [24:0] q_b;
    logic [23:0] rxd_b;

    logic loop_a = 1'b0, rnd_miso = 1'b0;
    assign miso_a = loop_a ? mosi_a : rnd_miso;
    assign miso_b = mosi_b;

    spi_fifo_sequencer #(.CLK_DIV(4), .CS_GAP(2)) u_a (
        .clock(clock), .sclr(sclr), .enable(en_a), .fifo_empty(empty_a), .fifo_q(q_a),
        .fifo_rdreq(rdreq_a), .spi_sclk(sclk_a), .spi_cs_n(cs_a), .spi_mosi(mosi_a),
        .spi_miso(miso_a), .rx_data(rxd_a), .rx_valid(rxv_a), .busy(busy_a));

    spi_fifo_sequencer #(.CLK_DIV(1), .CS_GAP(2)) u_b (
        .clock(clock), .sclr(sclr), .enable(en_b), .fifo_empty(empty_b), .fifo_q(q_b),
        .fifo_rdreq(rdreq_b), .spi_sclk(sclk_b), .spi_cs_n(cs_b), .spi_mosi(mosi_b),
        .spi_miso(miso_b), .rx_data(rxd_b), .rx_valid(rxv_b), .busy(busy_b));

    // FIFO contents, slave-side observations and scoreboard state
    logic [24:0] qa[$], qb[$];
    logic [23:0] tx_seen[$], rx_model[$], rx_seen[$], rx_seen_b[$];
    logic [23:0] mo_sr = '0, mi_sr = '0;
    int cs_runs[$], rd_t_b[$];
    int cs_run = 0, gap_run = 0, rdreq_cnt = 0, pop_empty = 0, nbits = 0;
    int cyc = 0, rises_b = 0, cs_run_b = 0;
    logic psclk_a = 1'b0, psclk_b = 1'b0;
    int n_chk = 0, n_fail = 0;

    // show-ahead FIFO: pop on the edge that sees rdreq
    always @(posedge clock) begin
        if (rdreq_a) begin
            if (qa.size() == 0) pop_empty++;
            else void'(qa.pop_front());
        end
        if (rdreq_b) begin
            if (qb.size() == 0) pop_empty++;
            else void'(qb.pop_front());
        end
    end

    always @(negedge clock) begin
        empty_a = (qa.size() == 0);
        q_a     = empty_a ? 25'd0 : qa[0];
        empty_b = (qb.size() == 0);
        q_b     = empty_b ? 25'd0 : qb[0];
        cyc++;
        if (sclr) begin
            nbits = 0;
        end else begin
            // mode-0 slave: sample both lines on SCLK rise, change MISO after SCLK fall
            if (sclk_a && !psclk_a && !cs_a) begin
                mo_sr = {mo_sr[22:0], mosi_a};
                mi_sr = {mi_sr[22:0], miso_a};
                nbits++;
                if (nbits == 24) begin
                    tx_seen.push_back(mo_sr);
                    rx_model.push_back(mi_sr);
                    nbits = 0;
                end
            end
            if (!sclk_a && psclk_a) rnd_miso = 1'($urandom_range(0, 1));
            if (rxv_a) rx_seen.push_back(rxd_a);
            if (rdreq_a) rdreq_cnt++;
            if (!cs_a) cs_run++;
            else if (cs_run > 0) begin cs_runs.push_back(cs_run); cs_run = 0; end
            if (cs_a && busy_a) gap_run++;
            if (sclk_b && !psclk_b) rises_b++;
            if (rxv_b) rx_seen_b.push_back(rxd_b);
            if (rdreq_b) rd_t_b.push_back(cyc);
            if (!cs_b) cs_run_b++;
        end
        psclk_a = sclk_a;
        psclk_b = sclk_b;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic clear_mon();
        tx_seen.delete(); rx_model.delete(); rx_seen.delete(); rx_seen_b.delete();
        cs_runs.delete(); rd_t_b.delete();
        cs_run = 0; gap_run = 0; rdreq_cnt = 0; rises_b = 0; cs_run_b = 0;
    endtask

    task automatic wait_idle_a(input int budget, output bit ok);
        int k = 0;
        step(3);
        while ((busy_a || qa.size() != 0) && k < budget) begin step(1); k++; end
        ok = (k < budget);
    endtask

    task automatic test_reset();
        sclr = 1'b1; en_a = 1'b0; en_b = 1'b0;
        step(3);
        n_chk++;
        if ({sclk_a, cs_a, mosi_a, rdreq_a, rxd_a, rxv_a, busy_a} !== {4'b0100, 24'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_a: got sclk=%b cs=%b mosi=%b rdreq=%b rx=%h rxv=%b busy=%b, want 0 1 0 0 000000 0 0",
                     sclk_a, cs_a, mosi_a, rdreq_a, rxd_a, rxv_a, busy_a);
        end
        n_chk++;
        if ({sclk_b, cs_b, mosi_b, rdreq_b, rxd_b, rxv_b, busy_b} !== {4'b0100, 24'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_b: got sclk=%b cs=%b busy=%b rx=%h, want 0 1 0 000000", sclk_b, cs_b, busy_b, rxd_b);
        end
        sclr = 1'b0;
        step(2);
    endtask

    task automatic test_single_word();
        bit ok; logic [23:0] got;
        clear_mon(); loop_a = 1'b0;
        qa.push_back({1'b1, 24'hA5A5A5});
        en_a = 1'b1;
        wait_idle_a(2000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL single_timeout: busy=%b still set, want idle", busy_a); end
        n_chk++; if (rdreq_cnt != 1) begin n_fail++; $display("FAIL single_rdreq: got %0d pulses, want 1", rdreq_cnt); end
        n_chk++;
        if (cs_runs.size() != 1 || cs_runs[0] != 193) begin
            n_fail++; $display("FAIL single_cs_len: got %0d runs first=%0d, want 1 run of 193",
                               cs_runs.size(), (cs_runs.size() > 0) ? cs_runs[0] : -1);
        end
        got = (tx_seen.size() > 0) ? tx_seen[0] : 24'hxxxxxx;
        n_chk++;
        if (tx_seen.size() != 1 || got !== 24'hA5A5A5) begin
            n_fail++; $display("FAIL single_mosi: got %0d words first=%h, want A5A5A5", tx_seen.size(), got);
        end
        got = (rx_seen.size() > 0) ? rx_seen[0] : 24'hxxxxxx;
        n_chk++;
        if (rx_seen.size() != 1 || rx_model.size() != 1 || got !== rx_model[0]) begin
            n_fail++; $display("FAIL single_rx: got %0d words first=%h, want %h", rx_seen.size(), got,
                               (rx_model.size() > 0) ? rx_model[0] : 24'hxxxxxx);
        end
        n_chk++; if (gap_run != 2) begin n_fail++; $display("FAIL single_gap: got %0d cycles, want 2", gap_run); end
        n_chk++; if ({busy_a, cs_a} !== 2'b01) begin n_fail++; $display("FAIL single_end: busy=%b cs=%b, want 0 1", busy_a, cs_a); end
    endtask

    task automatic test_loopback();
        bit ok;
        clear_mon(); loop_a = 1'b1;
        qa.push_back({1'b0, 24'h123456});
        qa.push_back({1'b1, 24'hFEDCBA});
        wait_idle_a(2000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL loop_timeout: busy=%b, want idle", busy_a); end
        n_chk++;
        if (cs_runs.size() != 1 || cs_runs[0] != 386) begin
            n_fail++; $display("FAIL loop_cs: got %0d runs first=%0d, want 1 run of 386",
                               cs_runs.size(), (cs_runs.size() > 0) ? cs_runs[0] : -1);
        end
        n_chk++;
        if (rx_seen.size() != 2 || rx_seen[0] !== 24'h123456 || rx_seen[1] !== 24'hFEDCBA) begin
            n_fail++; $display("FAIL loop_rx: got %0d words %h %h, want 123456 FEDCBA", rx_seen.size(),
                               (rx_seen.size() > 0) ? rx_seen[0] : 24'hx, (rx_seen.size() > 1) ? rx_seen[1] : 24'hx);
        end
        n_chk++; if (rdreq_cnt != 2) begin n_fail++; $display("FAIL loop_rdreq: got %0d, want 2", rdreq_cnt); end
        loop_a = 1'b0;
    endtask

    task automatic test_stall();
        bit ok; int k = 0, bad = 0;
        clear_mon();
        qa.push_back({1'b0, 24'h000001});
        while (rx_seen.size() == 0 && k < 1000) begin step(1); k++; end
        n_chk++; if (k >= 1000) begin n_fail++; $display("FAIL stall_first_word: no rx_valid, want one"); end
        for (int i = 0; i < 100; i++) begin
            step(1);
            if ({cs_a, sclk_a, busy_a} !== 3'b001) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL stall_lines: %0d bad cycles, want cs=0 sclk=0 busy=1 always", bad); end
        n_chk++; if (rdreq_cnt != 1) begin n_fail++; $display("FAIL stall_rdreq: got %0d pops, want 1", rdreq_cnt); end
        qa.push_back({1'b1, 24'h800000});
        wait_idle_a(2000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: busy=%b, want idle", busy_a); end
        n_chk++;
        if (tx_seen.size() != 2 || tx_seen[0] !== 24'h000001 || tx_seen[1] !== 24'h800000) begin
            n_fail++; $display("FAIL stall_mosi: got %0d words, want 000001 800000", tx_seen.size());
        end
        n_chk++; if (cs_runs.size() != 1) begin n_fail++; $display("FAIL stall_cs: got %0d cs frames, want 1", cs_runs.size()); end
        n_chk++; if (rx_seen != rx_model) begin n_fail++; $display("FAIL stall_rx: got %0d words, want %0d matching", rx_seen.size(), rx_model.size()); end
        n_chk++; if (pop_empty != 0) begin n_fail++; $display("FAIL stall_pop_empty: got %0d, want 0", pop_empty); end
    endtask

    task automatic test_abort();
        bit ok; int k = 0; logic [23:0] w1, w2;
        clear_mon();
        w1 = 24'($urandom); w2 = 24'($urandom);
        qa.push_back({1'b1, w1});
        qa.push_back({1'b1, w2});
        while (nbits != 10 && k < 1000) begin step(1); k++; end
        n_chk++; if (k >= 1000) begin n_fail++; $display("FAIL abort_reach_bit10: nbits=%0d, want 10", nbits); end
        sclr = 1'b1;
        step(1);
        n_chk++;
        if ({cs_a, sclk_a, mosi_a, busy_a, rxv_a} !== 5'b10000) begin
            n_fail++; $display("FAIL abort_lines: cs=%b sclk=%b mosi=%b busy=%b rxv=%b, want 1 0 0 0 0",
                               cs_a, sclk_a, mosi_a, busy_a, rxv_a);
        end
        sclr = 1'b0;
        n_chk++; if (rx_seen.size() != 0) begin n_fail++; $display("FAIL abort_rxv: got %0d rx words, want 0", rx_seen.size()); end
        wait_idle_a(2000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL abort_timeout: busy=%b, want idle", busy_a); end
        n_chk++;
        if (tx_seen.size() != 1 || tx_seen[0] !== w2) begin
            n_fail++; $display("FAIL abort_next_word: got %0d words first=%h, want %h", tx_seen.size(),
                               (tx_seen.size() > 0) ? tx_seen[0] : 24'hx, w2);
        end
        n_chk++; if (rx_seen != rx_model || rx_seen.size() != 1) begin n_fail++; $display("FAIL abort_rx: got %0d words, want 1 matching", rx_seen.size()); end
    endtask

    task automatic test_enable();
        bit ok; int k = 0; logic [23:0] r1, r2;
        clear_mon();
        en_a = 1'b0;
        r1 = 24'($urandom); r2 = 24'($urandom);
        qa.push_back({1'b0, r1});
        qa.push_back({1'b1, r2});
        step(50);
        n_chk++; if (rdreq_cnt != 0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL en_hold: rdreq=%0d busy=%b, want 0 0", rdreq_cnt, busy_a); end
        en_a = 1'b1;
        while (rdreq_cnt == 0 && k < 20) begin step(1); k++; end
        en_a = 1'b0;
        wait_idle_a(2000, ok);
        n_chk++; if (!ok || k >= 20) begin n_fail++; $display("FAIL en_timeout: busy=%b start_wait=%0d, want idle", busy_a, k); end
        n_chk++;
        if (tx_seen.size() != 2 || tx_seen[0] !== r1 || tx_seen[1] !== r2) begin
            n_fail++; $display("FAIL en_frame: got %0d words, want %h %h", tx_seen.size(), r1, r2);
        end
        n_chk++; if (rx_seen != rx_model || rx_seen.size() != 2) begin n_fail++; $display("FAIL en_rx: got %0d words, want 2 matching", rx_seen.size()); end
        n_chk++; if (cs_runs.size() != 1) begin n_fail++; $display("FAIL en_cs: got %0d frames, want 1", cs_runs.size()); end
    endtask

    task automatic test_clkdiv1();
        int k = 0; logic [23:0] w1, w2;
        clear_mon();
        w1 = 24'($urandom); w2 = 24'($urandom);
        qb.push_back({1'b0, w1});
        qb.push_back({1'b1, w2});
        en_b = 1'b1;
        step(3);
        while ((busy_b || qb.size() != 0) && k < 500) begin step(1); k++; end
        en_b = 1'b0;
        step(2);
        n_chk++; if (k >= 500) begin n_fail++; $display("FAIL div1_timeout: busy=%b, want idle", busy_b); end
        n_chk++;
        if (rd_t_b.size() != 2 || rd_t_b[1] - rd_t_b[0] != 49) begin
            n_fail++; $display("FAIL div1_period: got %0d pops spacing %0d, want 2 spacing 49", rd_t_b.size(),
                               (rd_t_b.size() > 1) ? rd_t_b[1] - rd_t_b[0] : -1);
        end
        n_chk++; if (rises_b != 48 || cs_run_b != 98) begin n_fail++; $display("FAIL div1_sclk: rises=%0d cs_low=%0d, want 48 98", rises_b, cs_run_b); end
        n_chk++;
        if (rx_seen_b.size() != 2 || rx_seen_b[0] !== w1 || rx_seen_b[1] !== w2) begin
            n_fail++; $display("FAIL div1_rx: got %0d words, want %h %h", rx_seen_b.size(), w1, w2);
        end
    endtask

    initial begin
        sclr = 1'b1; en_a = 1'b0; en_b = 1'b0;
        test_reset();
        test_single_word();
        test_loopback();
        test_stall();
        test_abort();
        test_enable();
        test_clkdiv1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
